// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported, fixed-latency memory between the
//               instruction-fetch and data-memory stages. It latches the
//               granted request, holds the memory command for WAIT_CYCLES,
//               returns registered read data with a one-cycle ack, and raises
//               freeze while a data access is outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    // data memory port
    input  logic              dm_rd_en,
    input  logic              dm_wr_en,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              freeze,
    // memory array port
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_IF_BUSY = 2'd1;
    localparam logic [1:0] S_DM_BUSY = 2'd2;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_DM = 1'b1;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    logic              if_ack_q, dm_ack_q;
    logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

    logic w_dm_req;
    logic w_if_elig, w_dm_elig;
    logic w_grant_if, w_grant_dm;
    logic w_done;
    logic w_mem_rd, w_mem_wr;

    // A requester whose ack is showing this cycle still has its level request
    // up; masking it here keeps that stale request from being served twice.
    assign w_dm_req  = dm_rd_en | dm_wr_en;
    assign w_if_elig = if_req   & ~if_ack_q;
    assign w_dm_elig = w_dm_req & ~dm_ack_q;

    // State register: FSM state and hold-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, count out the memory latency when busy
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        w_grant_if = 1'b0;
        w_grant_dm = 1'b0;
        w_done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // On conflict the side not served last wins, so persistent
                // requests alternate and neither starves.
                if (w_dm_elig && (!w_if_elig || last_grant_q == GRANT_IF)) begin
                    w_grant_dm = 1'b1;
                    state_d    = S_DM_BUSY;
                end else if (w_if_elig) begin
                    w_grant_if = 1'b1;
                    state_d    = S_IF_BUSY;
                end
            end
            S_IF_BUSY, S_DM_BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    w_done  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: memory commands exist only in the busy states
    always_comb begin
        w_mem_rd = 1'b0;
        w_mem_wr = 1'b0;
        case (state_q)
            S_IF_BUSY: w_mem_rd = 1'b1;
            S_DM_BUSY: begin
                w_mem_rd = ~wr_q;
                w_mem_wr = wr_q;
            end
            default: begin
                w_mem_rd = 1'b0;
                w_mem_wr = 1'b0;
            end
        endcase
    end

    // Datapath: latch the granted command, capture read data and pulse acks
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GRANT_IF;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            if_ack_q <= w_done && (state_q == S_IF_BUSY);
            dm_ack_q <= w_done && (state_q == S_DM_BUSY);

            if (w_grant_dm) begin
                addr_q       <= dm_addr;
                wdata_q      <= dm_wdata;
                wr_q         <= dm_wr_en;   // write takes precedence over read
                last_grant_q <= GRANT_DM;
            end else if (w_grant_if) begin
                addr_q       <= if_addr;
                wr_q         <= 1'b0;
                last_grant_q <= GRANT_IF;
            end

            if (w_done && state_q == S_IF_BUSY) begin
                if_rdata_q <= mem_rdata;
            end
            if (w_done && state_q == S_DM_BUSY && !wr_q) begin
                dm_rdata_q <= mem_rdata;
            end
        end
    end

    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_rd    = w_mem_rd;
    assign mem_wr    = w_mem_wr;
    assign freeze    = w_dm_req & ~dm_ack_q;

endmodule
`default_nettype wire
